// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers and default geometry for the stream FIFO.
// Used by stream_fifo_rd and stream_fifo_mem (optional STREAM_FIFO_ERR_EN adds no types here).
package stream_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Pointer indexes DEPTH entries; DEPTH is a power of two so pointers wrap naturally.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/stream_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_rd.sv
// First-word fall-through stream FIFO with valid/ready on both sides and a global enable.
// Define STREAM_FIFO_ERR_EN to add sticky overflow/underflow flags (ovf, udf).
module stream_fifo_rd
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
`ifdef STREAM_FIFO_ERR_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Readiness is purely a function of occupancy, so no out_ready -> in_ready path exists.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = en && !full;
    assign out_valid = en && !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef STREAM_FIFO_ERR_EN
    // Sticky misuse flags: an offer into a full FIFO, or a read attempt on an empty one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (in_valid && en && full) begin
                ovf <= 1'b1;
            end
            if (out_ready && en && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/stream_fifo_rd.md
STREAM_FIFO_RD -- requirements
Module: stream_fifo_rd

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries; legal values are powers of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  global advance enable; 0 freezes all state.
REQ-006 in_valid  input  1  writer offers in_data this cycle.
REQ-007 in_data  input  WIDTH  write word.
REQ-008 in_ready  output  1  FIFO accepts a word this cycle.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_data  output  WIDTH  head word (first-word fall-through).
REQ-011 out_ready  input  1  reader consumes the head word this cycle.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-013 in_ready SHALL equal en AND (count != DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-014 out_valid SHALL equal en AND (count != 0).
REQ-015 A push SHALL occur on a rising edge where in_valid AND in_ready; the word is written at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-016 A pop SHALL occur on a rising edge where out_valid AND out_ready; rd_ptr increments modulo DEPTH.
REQ-017 out_data SHALL be driven combinationally from the storage entry at rd_ptr; it is don't-care while out_valid=0.
REQ-018 Latency: a word pushed into an empty FIFO on edge N SHALL appear with out_valid=1 in the cycle after edge N.
REQ-019 count SHALL be +1 on a push only, -1 on a pop only, and unchanged on a simultaneous push and pop or when there is no transfer.
REQ-020 Full (count=DEPTH): a push SHALL be refused even if a pop occurs in the same cycle; a pop is allowed.
REQ-021 Empty (count=0): no pop SHALL occur; a push in the same cycle is accepted, and out_valid rises on the next cycle.
REQ-022 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; word order SHALL be strictly preserved.
REQ-023 While en=0, pointers, count and storage SHALL hold their values and no handshake SHALL complete.

Reset
REQ-024 When rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, so the next cycle has out_valid=0 and in_ready=en.
REQ-025 rst SHALL take priority over en and over any push or pop in the same cycle; the in-flight word is dropped.
REQ-026 Storage contents SHALL NOT be reset.

Configuration
REQ-027 Macro STREAM_FIFO_ERR_EN: when defined, the module SHALL add output ports ovf and udf (1 bit each).
REQ-028 With STREAM_FIFO_ERR_EN, ovf SHALL set sticky when in_valid=1, en=1 and count=DEPTH; udf SHALL set sticky when out_ready=1, en=1 and count=0; both SHALL be cleared only by rst.
REQ-029 Without STREAM_FIFO_ERR_EN, the ovf and udf ports and their logic SHALL be absent, and the rest of the behaviour SHALL be identical.

Structure
REQ-030 Package stream_fifo_pkg SHALL hold the pointer-width and count-width helper constants and the default WIDTH/DEPTH values.
REQ-031 Storage SHALL be a sub-module stream_fifo_mem with WIDTH x DEPTH flops, one write port and one asynchronous read port, and no reset.
REQ-032 Pointer, count and handshake logic SHALL reside in stream_fifo_rd.

Verification
REQ-033 With rst then en=1, push 0x11, 0x22, 0x33 on consecutive cycles -> out_valid rises one cycle after the first push, and the pops return 0x11, 0x22, 0x33 with count going 1,2,3 then back to 0.
REQ-034 With DEPTH=16, push 16 words with out_ready=0 -> count=16, in_ready=0; a 17th offer (0xAA) is not stored; pop and push together -> count stays at 15 after the first pop, not 16.
REQ-035 Streaming with in_valid=1 and out_ready=1 for 40 cycles (values 0..39) -> count stays at 1 and the output sequence is 0..39 in order across pointer wrap.
REQ-036 With the FIFO holding 5 words, drop en to 0 for 3 cycles while toggling in_valid and out_ready -> count stays at 5, and in_ready=0 and out_valid=0 throughout.
REQ-037 Assert rst with count=7 and a push pending -> next cycle count=0 and out_valid=0; the pending word is not output later.
REQ-038 With STREAM_FIFO_ERR_EN: offer a push while full -> ovf=1 and it stays 1 until rst; pulse out_ready while empty -> udf=1.
